// File: rtl/acc_req_arbiter.sv
// Round-robin arbiter sharing one in-order accelerator request/response port among NumReq requesters.
// Grants load a registered output stage. A route FIFO of requester indices steers the in-order responses back.
module acc_req_arbiter #(
  parameter int NumReq         = 4,
  parameter int ReqWidth       = 128,
  parameter int RespWidth      = 64,
  parameter int MaxOutstanding = 8
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NumReq*ReqWidth-1:0]           req_data_i,
  input  logic [NumReq-1:0]                    req_valid_i,
  output logic [NumReq-1:0]                    req_ready_o,
  output logic [ReqWidth-1:0]                  acc_req_o,
  output logic                                 acc_req_valid_o,
  input  logic                                 acc_req_ready_i,
  input  logic [RespWidth-1:0]                 acc_resp_i,
  input  logic                                 acc_resp_valid_i,
  output logic                                 acc_resp_ready_o,
  output logic [RespWidth-1:0]                 resp_o,
  output logic [NumReq-1:0]                    resp_valid_o,
  input  logic [NumReq-1:0]                    resp_ready_i,
  output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o,
  output logic                                 spurious_resp_o
);

  localparam int IdxW = $clog2(NumReq);
  localparam int PtrW = $clog2(MaxOutstanding);
  localparam int CntW = $clog2(MaxOutstanding+1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

  logic [ReqWidth-1:0] acc_req_r;
  logic                acc_req_valid_r;
  logic [IdxW-1:0]     rr_r;
  logic [IdxW-1:0]     win_idx_s;
  logic [IdxW:0]       sum_s;
  logic                win_found_s;
  logic                stage_free_s;
  logic                grant_s;
  logic [IdxW-1:0]     route_mem_r [MaxOutstanding];
  logic [PtrW-1:0]     wr_ptr_r;
  logic [PtrW-1:0]     rd_ptr_r;
  logic [CntW-1:0]     count_r;
  logic [IdxW-1:0]     head_s;
  logic                head_sent_s;
  logic                pop_s;
  logic                spurious_r;

  assign stage_free_s = !acc_req_valid_r || acc_req_ready_i;
  assign grant_s      = !rst_i && stage_free_s && (count_r < MaxCnt) && win_found_s;
  assign head_s       = route_mem_r[rd_ptr_r];
  // The head may only retire once its request has left the output stage.
  assign head_sent_s  = count_r > CntW'(acc_req_valid_r);

  // Round-robin search starting at rr_r, wrapping modulo NumReq
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    sum_s       = '0;
    for (int i = 0; i < NumReq; i++) begin
      sum_s = {1'b0, rr_r} + (IdxW+1)'(i);
      if (sum_s >= (IdxW+1)'(NumReq)) begin
        sum_s = sum_s - (IdxW+1)'(NumReq);
      end else begin
        sum_s = sum_s;
      end
      if (!win_found_s && req_valid_i[sum_s[IdxW-1:0]]) begin
        win_found_s = 1'b1;
        win_idx_s   = sum_s[IdxW-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // One-hot grant to the search winner
  always_comb begin
    req_ready_o = '0;
    if (grant_s) begin
      req_ready_o[win_idx_s] = 1'b1;
    end else begin
      req_ready_o = '0;
    end
  end

  // Response steering by route FIFO head; an empty FIFO drops the response
  always_comb begin
    resp_valid_o     = '0;
    acc_resp_ready_o = 1'b0;
    pop_s            = 1'b0;
    if (rst_i) begin
      acc_resp_ready_o = 1'b0;
    end else if (count_r == '0) begin
      acc_resp_ready_o = 1'b1;
    end else if (head_sent_s) begin
      resp_valid_o[head_s] = acc_resp_valid_i;
      acc_resp_ready_o     = resp_ready_i[head_s];
      pop_s                = acc_resp_valid_i && resp_ready_i[head_s];
    end else begin
      acc_resp_ready_o = 1'b0;
    end
  end

  // Output stage, RR pointer and route FIFO state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_req_r       <= '0;
      acc_req_valid_r <= 1'b0;
      rr_r            <= '0;
      wr_ptr_r        <= '0;
      rd_ptr_r        <= '0;
      count_r         <= '0;
      spurious_r      <= 1'b0;
      for (int i = 0; i < MaxOutstanding; i++) begin
        route_mem_r[i] <= '0;
      end
    end else begin
      if (grant_s) begin
        acc_req_r             <= req_data_i[win_idx_s*ReqWidth +: ReqWidth];
        acc_req_valid_r       <= 1'b1;
        route_mem_r[wr_ptr_r] <= win_idx_s;
        wr_ptr_r              <= wr_ptr_r + PtrW'(1);
        rr_r                  <= (win_idx_s == IdxW'(NumReq-1)) ? '0 : win_idx_s + IdxW'(1);
      end else if (acc_req_valid_r && acc_req_ready_i) begin
        acc_req_valid_r <= 1'b0;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PtrW'(1);
      end
      case ({grant_s, pop_s})
        2'b10:   count_r <= count_r + CntW'(1);
        2'b01:   count_r <= count_r - CntW'(1);
        default: count_r <= count_r;
      endcase
      if (count_r == '0 && acc_resp_valid_i) begin
        spurious_r <= 1'b1;
      end
    end
  end

  assign acc_req_o       = acc_req_r;
  assign acc_req_valid_o = acc_req_valid_r;
  assign resp_o          = rst_i ? '0 : acc_resp_i;
  assign outstanding_o   = count_r;
  assign spurious_resp_o = spurious_r;

endmodule

// File: tb/tb_acc_req_arbiter.sv
// Directed and random stimulus for acc_req_arbiter, checked against a queue-based reference model.
module tb_acc_req_arbiter;

  localparam int N  = 4;
  localparam int RW = 128;
  localparam int SW = 64;
  localparam int MO = 8;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic [N*RW-1:0] req_data_i;
  logic [N-1:0]   req_valid_i;
  logic [N-1:0]   req_ready_o;
  logic [RW-1:0]  acc_req_o;
  logic           acc_req_valid_o;
  logic           acc_req_ready_i;
  logic [SW-1:0]  acc_resp_i;
  logic           acc_resp_valid_i;
  logic           acc_resp_ready_o;
  logic [SW-1:0]  resp_o;
  logic [N-1:0]   resp_valid_o;
  logic [N-1:0]   resp_ready_i;
  logic [3:0]     outstanding_o;
  logic           spurious_resp_o;

  acc_req_arbiter #(.NumReq(N), .ReqWidth(RW), .RespWidth(SW), .MaxOutstanding(MO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_data_i(req_data_i), .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o), .acc_req_o(acc_req_o), .acc_req_valid_o(acc_req_valid_o),
    .acc_req_ready_i(acc_req_ready_i), .acc_resp_i(acc_resp_i), .acc_resp_valid_i(acc_resp_valid_i),
    .acc_resp_ready_o(acc_resp_ready_o), .resp_o(resp_o), .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready_i), .outstanding_o(outstanding_o), .spurious_resp_o(spurious_resp_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // reference model: queue of owners, one-entry output stage, pointer, sticky flag
  int            q[$];
  bit            m_valid;
  logic [RW-1:0] m_payload;
  int            rr;
  bit            m_spur;
  bit            pend[N];
  logic [RW-1:0] pdata[N];
  int            arrive_pct;

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_valid = 1'b0; m_payload = '0; rr = 0; m_spur = 1'b0;
    for (int k = 0; k < N; k++) pend[k] = 1'b0;
  endtask

  // New requests appear randomly; a pending request stays stable until granted
  task automatic drive();
    for (int k = 0; k < N; k++) begin
      if (!pend[k] && ($urandom_range(99) < arrive_pct)) begin
        pend[k]  = 1'b1;
        pdata[k] = {$urandom, $urandom, $urandom, $urandom};
      end
      req_valid_i[k]            = pend[k];
      req_data_i[k*RW +: RW]    = pdata[k];
    end
  endtask

  // Check outputs mid-cycle, then advance the model past the next rising edge
  task automatic step();
    int win, sent, h;
    bit empty0;
    logic [N-1:0] e_rr, e_rv;
    bit e_ar;
    #1;
    win = -1;
    if ((!m_valid || acc_req_ready_i) && q.size() < MO) begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = (rr + i) % N;
        if (win < 0 && req_valid_i[k[1:0]]) win = k;
      end
    end
    e_rr = (win >= 0) ? 4'(1 << win) : 4'b0000;
    empty0 = (q.size() == 0);
    sent = q.size() - int'(m_valid);
    e_rv = 4'b0000; e_ar = 1'b0; h = -1;
    if (empty0) e_ar = 1'b1;
    else if (sent > 0) begin
      h    = q[0];
      e_rv = acc_resp_valid_i ? 4'(1 << h) : 4'b0000;
      e_ar = resp_ready_i[h[1:0]];
    end
    chk("req_ready", RW'(req_ready_o), RW'(e_rr));
    chk("acc_req_valid", RW'(acc_req_valid_o), RW'(m_valid));
    if (m_valid) chk("acc_req", acc_req_o, m_payload);
    chk("outstanding", RW'(outstanding_o), RW'(q.size()));
    chk("resp_valid", RW'(resp_valid_o), RW'(e_rv));
    chk("acc_resp_ready", RW'(acc_resp_ready_o), RW'(e_ar));
    chk("resp_data", RW'(resp_o), RW'(acc_resp_i));
    chk("spurious", RW'(spurious_resp_o), RW'(m_spur));
    if (h >= 0 && acc_resp_valid_i && resp_ready_i[h[1:0]]) void'(q.pop_front());
    if (empty0 && acc_resp_valid_i) m_spur = 1'b1;
    if (m_valid && acc_req_ready_i) m_valid = 1'b0;
    if (win >= 0) begin
      m_valid   = 1'b1;
      m_payload = pdata[win];
      q.push_back(win);
      rr        = (win + 1) % N;
      pend[win] = 1'b0;
    end
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    #1;
    chk("rst_req_ready", RW'(req_ready_o), '0);
    chk("rst_acc_req_valid", RW'(acc_req_valid_o), '0);
    chk("rst_acc_req", acc_req_o, '0);
    chk("rst_resp_valid", RW'(resp_valid_o), '0);
    chk("rst_acc_resp_ready", RW'(acc_resp_ready_o), '0);
    chk("rst_outstanding", RW'(outstanding_o), '0);
    chk("rst_spurious", RW'(spurious_resp_o), '0);
    @(negedge clk_i);
    rst_i = 1'b0;
    model_clear();
  endtask

  // Respond to every accepted request as soon as it is eligible
  task automatic auto_resp();
    acc_resp_valid_i = (q.size() - int'(m_valid)) > 0;
    acc_resp_i       = {$urandom, $urandom};
  endtask

  initial begin
    rst_i = 1'b1; req_data_i = '0; req_valid_i = '0; acc_req_ready_i = 1'b0;
    acc_resp_i = '0; acc_resp_valid_i = 1'b0; resp_ready_i = '0; arrive_pct = 0;
    model_clear();
    @(negedge clk_i);
    do_reset();

    // single request from requester 1
    acc_req_ready_i = 1'b1; resp_ready_i = 4'hF;
    pend[1] = 1'b1; pdata[1] = {4{32'hA5A5A5A5}};
    drive(); step();
    drive(); step();
    acc_resp_valid_i = 1'b1; acc_resp_i = 64'h1234;
    drive(); step();
    acc_resp_valid_i = 1'b0;
    drive(); step();

    // fairness: everybody always valid, responses streaming back
    arrive_pct = 100;
    for (int c = 0; c < 14; c++) begin drive(); auto_resp(); step(); end
    acc_resp_valid_i = 1'b0;

    // backpressure with two requesters
    do_reset();
    arrive_pct = 0; pend[0] = 1'b1; pend[2] = 1'b1;
    pdata[0] = {4{32'h0000C0DE}}; pdata[2] = {4{32'h2222BEEF}};
    acc_req_ready_i = 1'b0;
    for (int c = 0; c < 6; c++) begin drive(); step(); end
    acc_req_ready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin drive(); step(); end

    // outstanding limit, then one response frees a slot
    do_reset();
    arrive_pct = 100;
    for (int c = 0; c < 11; c++) begin drive(); step(); end
    acc_resp_valid_i = 1'b1; acc_resp_i = 64'hBEEF;
    drive(); step();
    acc_resp_valid_i = 1'b0;
    for (int c = 0; c < 2; c++) begin drive(); step(); end

    // response stall: owner not ready, others ready
    acc_resp_valid_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      resp_ready_i = ~(4'(1 << q[0]));
      drive(); step();
    end
    resp_ready_i = 4'hF;
    drive(); step();
    acc_resp_valid_i = 1'b0;

    // spurious response, sticky
    do_reset();
    arrive_pct = 0;
    acc_resp_valid_i = 1'b1;
    drive(); step();
    acc_resp_valid_i = 1'b0;
    for (int c = 0; c < 3; c++) begin drive(); step(); end

    // reset in the middle of a burst with three outstanding
    do_reset();
    arrive_pct = 100;
    for (int c = 0; c < 3; c++) begin drive(); step(); end
    do_reset();
    for (int c = 0; c < 2; c++) begin drive(); step(); end

    // random traffic
    for (int c = 0; c < 600; c++) begin
      arrive_pct       = 40;
      acc_req_ready_i  = ($urandom_range(3) != 0);
      resp_ready_i     = 4'($urandom);
      acc_resp_valid_i = ($urandom_range(2) == 0) && ((q.size() - int'(m_valid)) > 0);
      acc_resp_i       = {$urandom, $urandom};
      drive(); step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acc_req_arbiter.md
Name: acc_req_arbiter

Overview:
- Shares the single core-side accelerator request/response port among NumReq requesters (e.g. several hart-local issue ports or a debug/DMA client) in front of one in-order accelerator.
- Round-robin arbitration with a registered request output stage.
- Responses return in order and are routed back to the originating requester via an internal route FIFO of requester indices.

Parameters:
- NumReq, 4, number of requesters (2..8)
- ReqWidth, 128, flattened accelerator request payload width in bits
- RespWidth, 64, flattened accelerator response payload width in bits
- MaxOutstanding, 8, maximum requests granted but not yet answered; power of two, 2..16

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- req_data_i  in  NumReq*ReqWidth  payloads; requester k occupies bits [k*ReqWidth +: ReqWidth]
- req_valid_i  in  NumReq  per-requester request valid
- req_ready_o  out  NumReq  per-requester grant/accept (one-hot or zero)
- acc_req_o  out  ReqWidth  request payload to accelerator
- acc_req_valid_o  out  1  request valid to accelerator
- acc_req_ready_i  in  1  accelerator accepts request
- acc_resp_i  in  RespWidth  response payload from accelerator
- acc_resp_valid_i  in  1  response valid
- acc_resp_ready_o  out  1  response accepted
- resp_o  out  RespWidth  response payload, broadcast to all requesters (equals acc_resp_i)
- resp_valid_o  out  NumReq  one-hot response valid to the owning requester
- resp_ready_i  in  NumReq  per-requester response ready
- outstanding_o  out  $clog2(MaxOutstanding+1)  route FIFO occupancy
- spurious_resp_o  out  1  sticky flag: response arrived with no request outstanding

Behaviour:
- Reset (async assert, sync deassert in clock domain): all outputs 0, output register empty, route FIFO empty, RR pointer 0 (requester 0 highest priority), sticky flag cleared. Assertion mid-transfer discards all state; in-flight accelerator responses are not tracked.

Output stage:
- Holds one request; it is free when empty, or when acc_req_valid_o && acc_req_ready_i in this cycle.
- acc_req_valid_o/acc_req_o driven directly from the register; payload stable while valid && !ready.

Arbitration, in each cycle where the output stage is free and outstanding_o < MaxOutstanding:
- Search for a valid requester starting at RR pointer, wrapping modulo NumReq.
- Winner k gets req_ready_o[k]=1 (combinational on req_valid_i); payload loads into the output register (visible next cycle, 1-cycle latency).
- k is pushed into the route FIFO; RR pointer becomes (k+1) mod NumReq.
- No winner: nothing changes and the pointer holds.
- Back-to-back: a new grant may occur in the same cycle the accelerator accepts the previous request, giving full throughput.

Occupancy:
- outstanding_o counts grants minus retired responses, including the request still in the output register.
- A response pop in the same cycle does NOT enable a grant when outstanding_o == MaxOutstanding; the grant waits one cycle.
- Simultaneous push and pop leaves the count unchanged; FIFO pointers wrap modulo MaxOutstanding.

Response routing, with h = route FIFO head:
- FIFO non-empty: resp_valid_o[h] = acc_resp_valid_i and acc_resp_ready_o = resp_ready_i[h]; all other resp_valid_o bits are 0.
- Handshake: pop the FIFO. Non-owner resp_ready_i bits are ignored.
- FIFO empty: resp_valid_o = 0 and acc_resp_ready_o = 1 (drop). If acc_resp_valid_i is high, set spurious_resp_o, which stays high until reset.
- A response may retire in the cycle after its request handshake, and never before the request has left the output register: it must remain in the FIFO.

Requester-side rule:
- Requesters keep valid/payload stable until ready. The arbiter does not check this; violations are a bench assertion.

Test Plan:
- Single request: req_valid_i=4'b0010, payload 0xA5..., acc_req_ready_i=1 -> req_ready_o=4'b0010 in cycle 0; acc_req_valid_o=1 with same payload in cycle 1; outstanding_o=1; response 0x1234 -> resp_valid_o=4'b0010, outstanding_o back to 0.
- Fairness: all four requesters continuously valid, accelerator always ready, responses 2 cycles later -> grant order 0,1,2,3,0,1... with one grant per cycle; each response routed one-hot in the same order.
- Backpressure: acc_req_ready_i=0 for 5 cycles with two requesters valid -> acc_req_o stable, no further req_ready_o; release -> next grant in the same cycle as acceptance.
- Outstanding limit: MaxOutstanding=8, no responses returned -> exactly 8 grants then req_ready_o=0; one response plus simultaneous pending request -> grant in the following cycle only.
- Response stall: owner resp_ready_i=0 while other bits are 1 -> acc_resp_ready_o=0 and FIFO unchanged until the owner is ready.
- Spurious and reset: acc_resp_valid_i with empty FIFO -> acc_resp_ready_o=1, spurious_resp_o=1 sticky; rst_i asserted mid-burst with 3 outstanding -> all outputs 0 immediately, outstanding_o=0, RR pointer 0.
